// File: rtl/mult_nxn_fast_param.sv
// Sequential unsigned WIDTHxWIDTH multiplier: one A_CHUNK x B_CHUNK partial product per cycle,
// with all-zero upper operand chunks skipped so small operands finish early.
module mult_nxn_fast_param #(
   parameter int WIDTH   = 32,
   parameter int A_CHUNK = 8,
   parameter int B_CHUNK = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   // state | meaning
   // IDLE  | waiting for start; product holds the last result
   // RUN   | accumulating a[i]*b[j] partial products, i inner, j outer

   localparam int NA = WIDTH / A_CHUNK;
   localparam int NB = WIDTH / B_CHUNK;
   localparam int PW = 2 * WIDTH;
   localparam int IW = (NA > 1) ? $clog2(NA) : 1;
   localparam int JW = (NB > 1) ? $clog2(NB) : 1;
   localparam int SW = $clog2(PW) + 1;

   generate
      if (WIDTH % A_CHUNK != 0) begin : g_bad_a_chunk
         $error("mult_nxn_fast_param: WIDTH must be a multiple of A_CHUNK");
      end
      if (WIDTH % B_CHUNK != 0) begin : g_bad_b_chunk
         $error("mult_nxn_fast_param: WIDTH must be a multiple of B_CHUNK");
      end
   endgenerate

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [WIDTH-1:0]           r_a;
   logic [WIDTH-1:0]           r_b;
   logic [IW-1:0]              r_i;
   logic [JW-1:0]              r_j;
   logic [IW-1:0]              r_a_last;
   logic [JW-1:0]              r_b_last;
   logic [PW-1:0]              r_product;
   logic                       r_done;

   logic [IW-1:0]              w_a_last;
   logic [JW-1:0]              w_b_last;
   logic [A_CHUNK-1:0]         w_ca;
   logic [B_CHUNK-1:0]         w_cb;
   logic [A_CHUNK+B_CHUNK-1:0] w_prod;
   logic [SW-1:0]              w_shift;
   logic [PW-1:0]              w_pp;
   logic                       w_i_wrap;
   logic                       w_last;

   // Index of the highest nonzero chunk of the incoming operands (0 when the operand is 0)
   always_comb begin
      w_a_last = '0;
      for (int k = 0; k < NA; k++) begin
         if (a[k*A_CHUNK +: A_CHUNK] != '0) w_a_last = IW'(k);
      end
   end

   always_comb begin
      w_b_last = '0;
      for (int k = 0; k < NB; k++) begin
         if (b[k*B_CHUNK +: B_CHUNK] != '0) w_b_last = JW'(k);
      end
   end

   assign w_ca     = r_a[r_i*A_CHUNK +: A_CHUNK];
   assign w_cb     = r_b[r_j*B_CHUNK +: B_CHUNK];
   assign w_prod   = w_ca * w_cb;
   assign w_shift  = SW'(r_i) * SW'(A_CHUNK) + SW'(r_j) * SW'(B_CHUNK);
   assign w_pp     = PW'(w_prod) << w_shift;
   assign w_i_wrap = (r_i == r_a_last);
   assign w_last   = (r_state == S_RUN) && w_i_wrap && (r_j == r_b_last);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a       <= '0;
         r_b       <= '0;
         r_i       <= '0;
         r_j       <= '0;
         r_a_last  <= '0;
         r_b_last  <= '0;
         r_product <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (start) begin
               r_a       <= a;
               r_b       <= b;
               r_i       <= '0;
               r_j       <= '0;
               r_a_last  <= w_a_last;
               r_b_last  <= w_b_last;
               r_product <= '0;
            end
         end else begin
            r_product <= r_product + w_pp;
            if (w_i_wrap) begin
               r_i <= '0;
               if (w_last) r_done <= 1'b1;
               else        r_j    <= r_j + 1'b1;
            end else begin
               r_i <= r_i + 1'b1;
            end
         end
      end
   end

   assign busy    = (r_state == S_RUN);
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_mult_nxn_fast_param.sv
// Directed and random checks of mult_nxn_fast_param (32/8/16 and 16/4/8) against an a*b model.
module tb_mult_nxn_fast_param;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        s32, s16;
   logic [31:0] a32, b32;
   logic [15:0] a16, b16;
   logic        busy32, done32, busy16, done16;
   logic [63:0] p32;
   logic [31:0] p16;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   mult_nxn_fast_param #(.WIDTH(32), .A_CHUNK(8), .B_CHUNK(16)) dut32 (
      .clk(clk), .reset(rst_n), .start(s32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .product(p32));

   mult_nxn_fast_param #(.WIDTH(16), .A_CHUNK(4), .B_CHUNK(8)) dut16 (
      .clk(clk), .reset(rst_n), .start(s16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .product(p16));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Number of chunks up to and including the highest nonzero one (at least 1)
   function automatic int neff(input longint unsigned v, input int w, input int c);
      int n = 1;
      for (int k = 0; k < w / c; k++)
         if (((v >> (k * c)) & ((64'd1 << c) - 64'd1)) != 0) n = k + 1;
      return n;
   endfunction

   function automatic logic [63:0] obs_p(input bit w16);
      return w16 ? {32'd0, p16} : p32;
   endfunction

   // Caller is at a negedge; returns at the negedge where done should be high.
   task automatic do_op(input bit w16, input logic [31:0] av, input logic [31:0] bv,
                        input int poke_at, input string tag);
      longint unsigned ea, eb, ep;
      int  ecyc, cyc;
      bit  ended;
      if (w16) begin
         ea = 64'(av[15:0]); eb = 64'(bv[15:0]);
         ecyc = neff(ea, 16, 4) * neff(eb, 16, 8);
         a16 = av[15:0]; b16 = bv[15:0]; s16 = 1'b1;
      end else begin
         ea = 64'(av); eb = 64'(bv);
         ecyc = neff(ea, 32, 8) * neff(eb, 32, 16);
         a32 = av; b32 = bv; s32 = 1'b1;
      end
      ep = ea * eb;
      @(negedge clk);
      s16 = 1'b0; s32 = 1'b0;
      chk({tag, "_busy0"}, 64'(w16 ? busy16 : busy32), 64'd1);
      chk({tag, "_clr"}, obs_p(w16), 64'd0);
      chk({tag, "_nodone0"}, 64'(w16 ? done16 : done32), 64'd0);
      cyc = 1;
      ended = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         s16 = 1'b0; s32 = 1'b0;
         if (!(w16 ? busy16 : busy32)) begin
            ended = 1'b1;
            break;
         end
         cyc++;
         if (cyc == poke_at) begin
            a32 = $urandom; b32 = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
            if (w16) s16 = 1'b1; else s32 = 1'b1;
         end
      end
      chk({tag, "_ended"}, 64'(ended), 64'd1);
      chk({tag, "_cycles"}, 64'(cyc), 64'(ecyc));
      chk({tag, "_done"}, 64'(w16 ? done16 : done32), 64'd1);
      chk({tag, "_product"}, obs_p(w16), ep);
   endtask

   task automatic idle_chk(input bit w16, input logic [63:0] ep, input string tag);
      @(negedge clk);
      chk({tag, "_done_drop"}, 64'(w16 ? done16 : done32), 64'd0);
      chk({tag, "_idle"}, 64'(w16 ? busy16 : busy32), 64'd0);
      chk({tag, "_hold"}, obs_p(w16), ep);
   endtask

   initial begin
      int dones;
      logic [31:0] ra, rb;
      rst_n = 1'b0;
      s32 = 1'b0; s16 = 1'b0; a32 = '0; b32 = '0; a16 = '0; b16 = '0;
      #12;
      chk("rst_busy", 64'(busy32), 64'd0);
      chk("rst_done", 64'(done32), 64'd0);
      chk("rst_prod", p32, 64'd0);
      chk("rst_prod16", {32'd0, p16}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "c1");
      chk("c1_const", p32, 64'hFFFF_FFFE_0000_0001);
      idle_chk(1'b0, 64'hFFFF_FFFE_0000_0001, "c1");
      do_op(1'b0, 32'h0000_00FF, 32'h0000_FFFF, 0, "c2");
      chk("c2_const", p32, 64'h0000_0000_00FE_FF01);
      do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0, "c3_b2b");
      chk("c3_const", p32, 64'h0000_0001_0000_0000);
      idle_chk(1'b0, 64'h0000_0001_0000_0000, "c3");
      do_op(1'b0, 32'h0, 32'h5, 0, "c4");
      idle_chk(1'b0, 64'd0, "c4");
      do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, "ign");
      idle_chk(1'b0, 64'hFFFF_FFFE_0000_0001, "ign");

      a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; s32 = 1'b1;
      @(negedge clk);
      s32 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy32), 64'd0);
      chk("abort_done", 64'(done32), 64'd0);
      chk("abort_prod", p32, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done32) dones++;
      end
      chk("abort_nodone", 64'(dones), 64'd0);
      chk("abort_prod_after", p32, 64'd0);
      do_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 0, "after_rst");

      do_op(1'b1, 32'h0000_FFFF, 32'h0000_00FF, 0, "c6");
      chk("c6_const", {32'd0, p16}, 64'h0000_0000_00FE_FF01);
      idle_chk(1'b1, 64'h0000_0000_00FE_FF01, "c6");

      for (int n = 0; n < 25; n++) begin
         ra = $urandom >> $urandom_range(0, 31);
         rb = $urandom >> $urandom_range(0, 31);
         do_op(1'b0, ra, rb, 0, "rnd32");
      end
      for (int n = 0; n < 25; n++) begin
         ra = $urandom >> $urandom_range(16, 31);
         rb = $urandom >> $urandom_range(16, 31);
         do_op(1'b1, ra, rb, 0, "rnd16");
      end
      idle_chk(1'b1, 64'(ra[15:0]) * 64'(rb[15:0]), "rnd16_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
